uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo_if.sv | 26 ++
 rtl/uart_rx_fifo.sv | 127 ++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver frame strobe and consumer valid/ready
// read port of the receive FIFO, bundled for the uart_rx_fifo ports.
//   rx_done/rx_data/p_error/stop_error  frame from the UART receiver
//   rd_valid/rd_ready/rd_data/rd_perr/rd_serr  FWFT head handshake
// master = producer/consumer side, slave = the FIFO itself.
interface uart_rx_fifo_if;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       p_error;
  logic       stop_error;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_perr;
  logic       rd_serr;

  modport master (
    output rx_done, rx_data, p_error, stop_error, rd_ready,
    input  rd_valid, rd_data, rd_perr, rd_serr
  );

  modport slave (
    input  rx_done, rx_data, p_error, stop_error, rd_ready,
    output rd_valid, rd_data, rd_perr, rd_serr
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT buffer for UART receive frames with drop/error counters.
// Ports: clk, reset (async, active-high), rx (uart_rx_fifo_if.slave:
//   frame in + head read handshake), ovf_clr (clears overflow/drop_cnt),
//   count, full, overflow (sticky), drop_cnt, err_cnt (saturating).
// Build option UART_RX_DROP_ERR_EN: discard frames carrying p_error or
//   stop_error and count them in err_cnt; otherwise err_cnt reads 0.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_rx_fifo_if.slave            rx,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] SAT = '1;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   count_nxt;
  logic [9:0]    din;
  logic [9:0]    head_q;
  logic [9:0]    head_nxt;
  logic          bad;
  logic          accept;
  logic          pop;
  logic          push;
  logic          drop;

`ifdef UART_RX_DROP_ERR_EN
  assign bad = rx.p_error | rx.stop_error;
`else
  assign bad = 1'b0;
`endif

  assign din    = {rx.stop_error, rx.p_error, rx.rx_data};
  assign accept = rx.rx_done & ~bad;
  assign pop    = rx.rd_valid & rx.rd_ready;
  assign push   = accept & (~full | pop);
  assign drop   = accept & full & ~pop;

  assign full        = count == CNT_FULL;
  assign rx.rd_valid = count != '0;
  assign rx.rd_data  = head_q[7:0];
  assign rx.rd_perr  = head_q[8];
  assign rx.rd_serr  = head_q[9];

  assign rd_ptr_nxt = rd_ptr + AW'(pop);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Head is registered; when the slot becoming head is written
  // this same cycle, forward the incoming frame.
  always_comb begin
    head_nxt = mem[rd_ptr_nxt];
    if (push && wr_ptr == rd_ptr_nxt)
      head_nxt = din;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      // Head holds its last value once empty.
      if (count_nxt != '0)
        head_q <= head_nxt;
    end
  end

  // A drop in the same cycle as ovf_clr wins and restarts the count at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr)
        drop_cnt <= CNT_W'(1);
      else if (drop_cnt != SAT)
        drop_cnt <= drop_cnt + CNT_W'(1);
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

`ifdef UART_RX_DROP_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_cnt <= '0;
    else if (rx.rx_done && bad && err_cnt != SAT)
      err_cnt <= err_cnt + CNT_W'(1);
  end
`else
  assign err_cnt = '0;
`endif

endmodule
